// File: rtl/aes_rkey_sched192_if.sv
// Key-load, expander and round-datapath signal bundle for aes_rkey_sched192.
//   key_in/key_vld/key_rdy          : cipher key offer from the core
//   kx_kt/kx_kt_vld/kx_kt_rdy       : key handed to the 192-bit key expander
//   kx_rkey/kx_rkey_vld/kx_rkey_last: round keys streamed back by the expander
//   rk_out/rk_vld/rk_rdy/rk_idx/rk_last : round keys served to the datapath
//   keys_ready/err                  : buffer status and sticky sequencing error
// The scheduler uses the slave modport; the surrounding core (or a bench) uses master.
interface aes_rkey_sched192_if;
    logic [0:191] key_in;
    logic         key_vld;
    logic         key_rdy;
    logic [0:191] kx_kt;
    logic         kx_kt_vld;
    logic         kx_kt_rdy;
    logic [0:127] kx_rkey;
    logic         kx_rkey_vld;
    logic         kx_rkey_last;
    logic [0:127] rk_out;
    logic         rk_vld;
    logic         rk_rdy;
    logic [3:0]   rk_idx;
    logic         rk_last;
    logic         keys_ready;
    logic         err;

    modport slave (
        input  key_in, key_vld, kx_kt_rdy, kx_rkey, kx_rkey_vld, kx_rkey_last, rk_rdy,
        output key_rdy, kx_kt, kx_kt_vld, rk_out, rk_vld, rk_idx, rk_last, keys_ready, err
    );

    modport master (
        output key_in, key_vld, kx_kt_rdy, kx_rkey, kx_rkey_vld, kx_rkey_last, rk_rdy,
        input  key_rdy, kx_kt, kx_kt_vld, rk_out, rk_vld, rk_idx, rk_last, keys_ready, err
    );
endinterface

// File: rtl/aes_rkey_sched192.sv
// Round-key scheduler for the AES-192 decryption path.
// Runs the external key expander once per cipher key, captures its 13 round keys
// into a local buffer and then replays them to the round datapath once per block
// (index 12 down to 0 when REVERSE = 1, 0 up to 12 otherwise).
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (the expander is reset from the same net)
//   bus   : aes_rkey_sched192_if.slave -- key load, expander and datapath handshakes
module aes_rkey_sched192 #(
    parameter bit REVERSE = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    aes_rkey_sched192_if.slave bus
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOAD    = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_READY   = 2'd3;

    localparam logic [3:0] START_IDX = REVERSE ? 4'd12 : 4'd0;
    localparam logic [3:0] END_IDX   = REVERSE ? 4'd0  : 4'd12;

    logic [1:0]   state_r;
    logic [3:0]   wr_ptr_r;
    logic [3:0]   rd_ptr_r;
    logic         keys_ready_r;
    logic         err_r;
    logic [0:191] key_reg_r;
    logic [0:127] rk_buf_r [0:12];

    logic         key_rdy_s;
    logic         key_take_s;
    logic         at_end_s;
    logic [3:0]   rd_step_s;

    // Key acceptance and read-pointer stepping helpers
    always_comb begin
        key_rdy_s  = (state_r == ST_IDLE) || ((state_r == ST_READY) && (rd_ptr_r == START_IDX));
        key_take_s = bus.key_vld && key_rdy_s;
        at_end_s   = (rd_ptr_r == END_IDX);
        if (REVERSE) begin
            rd_step_s = rd_ptr_r - 4'd1;
        end else begin
            rd_step_s = rd_ptr_r + 4'd1;
        end
    end

    // Output decode: serving outputs are live only in READY so stale buffer data never leaks
    always_comb begin
        bus.key_rdy    = key_rdy_s;
        bus.kx_kt      = key_reg_r;
        bus.kx_kt_vld  = (state_r == ST_LOAD);
        bus.keys_ready = keys_ready_r;
        bus.err        = err_r;
        if (state_r == ST_READY) begin
            bus.rk_vld  = 1'b1;
            bus.rk_out  = rk_buf_r[rd_ptr_r];
            bus.rk_idx  = rd_ptr_r;
            bus.rk_last = at_end_s;
        end else begin
            bus.rk_vld  = 1'b0;
            bus.rk_out  = 128'h0;
            bus.rk_idx  = 4'd0;
            bus.rk_last = 1'b0;
        end
    end

    // Control FSM, write/read pointers and status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            wr_ptr_r     <= 4'd0;
            rd_ptr_r     <= 4'd0;
            keys_ready_r <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (key_take_s) begin
                        state_r      <= ST_LOAD;
                        keys_ready_r <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    // Round key 0 appears combinationally in the same cycle the expander takes the key
                    if (bus.kx_kt_rdy && bus.kx_rkey_vld) begin
                        state_r  <= ST_CAPTURE;
                        wr_ptr_r <= 4'd1;
                    end
                end
                ST_CAPTURE: begin
                    if (bus.kx_rkey_vld) begin
                        if (bus.kx_rkey_last) begin
                            if (wr_ptr_r != 4'd12) begin
                                err_r <= 1'b1;
                            end
                            state_r      <= ST_READY;
                            keys_ready_r <= 1'b1;
                            rd_ptr_r     <= START_IDX;
                        end else if (wr_ptr_r <= 4'd12) begin
                            // Saturates at 13 if the expander overruns, so no entry is overwritten
                            wr_ptr_r <= wr_ptr_r + 4'd1;
                        end
                    end
                end
                ST_READY: begin
                    // A rekey can only win at block start, so it never truncates a block
                    if (key_take_s) begin
                        state_r      <= ST_LOAD;
                        keys_ready_r <= 1'b0;
                    end else if (bus.rk_rdy) begin
                        if (at_end_s) begin
                            rd_ptr_r <= START_IDX;
                        end else begin
                            rd_ptr_r <= rd_step_s;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Key register and round-key buffer; pure storage, contents are don't-care until READY
    always_ff @(posedge clk) begin
        if (key_take_s) begin
            key_reg_r <= bus.key_in;
        end
        if ((state_r == ST_LOAD) && bus.kx_kt_rdy && bus.kx_rkey_vld) begin
            rk_buf_r[0] <= bus.kx_rkey;
        end else if ((state_r == ST_CAPTURE) && bus.kx_rkey_vld && (wr_ptr_r <= 4'd12)) begin
            rk_buf_r[wr_ptr_r] <= bus.kx_rkey;
        end
    end

endmodule

// File: tb/tb_aes_rkey_sched192.sv
// Bench for aes_rkey_sched192: a behavioural AES-192 key expander feeds two
// schedulers (REVERSE = 1 and REVERSE = 0) in lockstep; served keys are compared
// with a reference key schedule computed in the bench and with FIPS-197 constants.
module tb_aes_rkey_sched192;

    localparam logic [0:191] KEY_C2 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [0:191] KEY_A2 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aes_rkey_sched192_if bus ();
    aes_rkey_sched192_if bus0 ();

    aes_rkey_sched192 #(.REVERSE(1'b1)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    aes_rkey_sched192 #(.REVERSE(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    // The second scheduler sees exactly the same inputs, so its load timing matches
    assign bus0.key_in       = bus.key_in;
    assign bus0.key_vld      = bus.key_vld;
    assign bus0.rk_rdy       = bus.rk_rdy;
    assign bus0.kx_kt_rdy    = bus.kx_kt_rdy;
    assign bus0.kx_rkey      = bus.kx_rkey;
    assign bus0.kx_rkey_vld  = bus.kx_rkey_vld;
    assign bus0.kx_rkey_last = bus.kx_rkey_last;

    int checks = 0;
    int errors = 0;

    // ---------------- AES-192 key expansion (reference) ----------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] b;
        p = x;
        for (int i = 0; i < 6; i++) p = gmul(gmul(p, p), x);
        b = gmul(p, p);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] t);
        return {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
    endfunction

    function automatic logic [0:1663] expand(input logic [0:191] k);
        logic [31:0]   w [52];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [0:1663] r;
        for (int i = 0; i < 6; i++) w[i] = k[32*i +: 32];
        rc = 8'h01;
        for (int i = 6; i < 52; i++) begin
            t = w[i-1];
            if (i % 6 == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = xtime(rc);
            end
            w[i] = w[i-6] ^ t;
        end
        for (int i = 0; i < 52; i++) r[32*i +: 32] = w[i];
        return r;
    endfunction

    function automatic logic [127:0] rk_of(input logic [0:1663] g, input int i);
        return g[128*i +: 128];
    endfunction

    // ---------------- behavioural expander ----------------
    logic [0:1663] exp_all;
    logic          exp_busy;
    logic          exp_tog;
    logic          exp_gap;
    logic          exp_vld;
    int            exp_idx;
    int            exp_last_at;

    assign exp_vld = exp_gap ? exp_tog : 1'b1;

    always @(posedge clk) begin
        if (!rst_n) begin
            exp_busy <= 1'b0;
            exp_idx  <= 0;
            exp_tog  <= 1'b0;
        end else if (!exp_busy) begin
            if (bus.kx_kt_vld) begin
                exp_all  <= expand(bus.kx_kt);
                exp_busy <= 1'b1;
                exp_idx  <= 1;
                exp_tog  <= 1'b0;
            end
        end else begin
            exp_tog <= ~exp_tog;
            if (exp_vld) begin
                if (exp_idx == exp_last_at) exp_busy <= 1'b0;
                else exp_idx <= exp_idx + 1;
            end
        end
    end

    always_comb begin
        if (!exp_busy) begin
            bus.kx_kt_rdy    = 1'b1;
            bus.kx_rkey      = bus.kx_kt[0:127];
            bus.kx_rkey_vld  = bus.kx_kt_vld;
            bus.kx_rkey_last = 1'b0;
        end else begin
            bus.kx_kt_rdy    = 1'b0;
            bus.kx_rkey      = exp_all[128*exp_idx +: 128];
            bus.kx_rkey_vld  = exp_vld;
            bus.kx_rkey_last = exp_vld && (exp_idx == exp_last_at);
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       rdy;
        logic [3:0] idx;
        logic       last;
        logic [3:0] idx0;
        logic       last0;
    } vec_t;

    vec_t vec [18];

    logic [0:1663] gold_c2;
    logic [0:1663] gold_a2;

    initial begin
        int n;
        int exp_i;
        int xfers;

        for (int k = 0; k < 13; k++) begin
            vec[k] = '{1'b1, 4'(12 - k), (k == 12), 4'(k), (k == 12)};
        end
        vec[13] = '{1'b1, 4'd12, 1'b0, 4'd0, 1'b0};
        vec[14] = '{1'b0, 4'd11, 1'b0, 4'd1, 1'b0};
        vec[15] = '{1'b0, 4'd11, 1'b0, 4'd1, 1'b0};
        vec[16] = '{1'b1, 4'd11, 1'b0, 4'd1, 1'b0};
        vec[17] = '{1'b1, 4'd10, 1'b0, 4'd2, 1'b0};

        gold_c2 = expand(KEY_C2);
        gold_a2 = expand(KEY_A2);

        rst_n       = 1'b0;
        bus.key_in  = '0;
        bus.key_vld = 1'b0;
        bus.rk_rdy  = 1'b0;
        exp_gap     = 1'b0;
        exp_last_at = 12;

        // Reset state
        cyc();
        cyc();
        @(negedge clk);
        chk("rst key_rdy", 128'(bus.key_rdy), 128'd1);
        chk("rst kx_kt_vld", 128'(bus.kx_kt_vld), 128'd0);
        chk("rst rk_vld", 128'(bus.rk_vld), 128'd0);
        chk("rst rk_last", 128'(bus.rk_last), 128'd0);
        chk("rst keys_ready", 128'(bus.keys_ready), 128'd0);
        chk("rst err", 128'(bus.err), 128'd0);
        chk("rst rk_idx", 128'(bus.rk_idx), 128'd0);
        rst_n = 1'b1;

        // Load FIPS-197 C.2 key at cycle T
        cyc();
        bus.key_in  = KEY_C2;
        bus.key_vld = 1'b1;
        bus.rk_rdy  = 1'b1;
        @(negedge clk);
        chk("T key_rdy", 128'(bus.key_rdy), 128'd1);
        cyc();
        bus.key_vld = 1'b0;
        @(negedge clk);
        chk("T+1 kx_kt_vld", 128'(bus.kx_kt_vld), 128'd1);
        chk("T+1 key_rdy", 128'(bus.key_rdy), 128'd0);
        repeat (12) cyc();
        @(negedge clk);
        chk("T+13 rk_vld", 128'(bus.rk_vld), 128'd0);
        chk("T+13 keys_ready", 128'(bus.keys_ready), 128'd0);
        cyc();

        // Serving table from T+14: full block, wrap, then a short backpressure pattern
        for (int k = 0; k < 18; k++) begin
            bus.rk_rdy = vec[k].rdy;
            @(negedge clk);
            chk($sformatf("tbl%0d rk_vld", k), 128'(bus.rk_vld), 128'd1);
            chk($sformatf("tbl%0d rk_idx", k), 128'(bus.rk_idx), 128'(vec[k].idx));
            chk($sformatf("tbl%0d rk_last", k), 128'(bus.rk_last), 128'(vec[k].last));
            chk($sformatf("tbl%0d rk_out", k), bus.rk_out, rk_of(gold_c2, int'(vec[k].idx)));
            chk($sformatf("tbl%0d rev0 idx", k), 128'(bus0.rk_idx), 128'(vec[k].idx0));
            chk($sformatf("tbl%0d rev0 last", k), 128'(bus0.rk_last), 128'(vec[k].last0));
            chk($sformatf("tbl%0d rev0 out", k), bus0.rk_out, rk_of(gold_c2, int'(vec[k].idx0)));
            if (k == 0) begin
                chk("T+14 keys_ready", 128'(bus.keys_ready), 128'd1);
                chk("T+14 rk12 const", bus.rk_out, 128'ha4970a331a78dc09c418c271e3a41d5d);
                chk("rev0 first const", bus0.rk_out, 128'h000102030405060708090a0b0c0d0e0f);
            end
            if (k == 12) begin
                chk("T+26 rk0 const", bus.rk_out, 128'h000102030405060708090a0b0c0d0e0f);
            end
            cyc();
        end

        // Random backpressure over three blocks
        exp_i = 9;
        xfers = 0;
        n     = 0;
        while (xfers < 39 && n < 500) begin
            bus.rk_rdy = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("bp rk_vld", 128'(bus.rk_vld), 128'd1);
            chk("bp rk_idx", 128'(bus.rk_idx), 128'(exp_i));
            chk("bp rk_last", 128'(bus.rk_last), 128'(exp_i == 0));
            chk("bp rk_out", bus.rk_out, rk_of(gold_c2, exp_i));
            if (bus.rk_rdy) begin
                xfers++;
                exp_i = (exp_i == 0) ? 12 : exp_i - 1;
            end
            n++;
            cyc();
        end
        chk("bp transfers", 128'(xfers), 128'd39);

        // Move to idx 5, then offer the A.2 key mid-block
        bus.rk_rdy = 1'b1;
        n = (exp_i >= 5) ? exp_i - 5 : exp_i + 8;
        repeat (n) cyc();
        bus.key_in  = KEY_A2;
        bus.key_vld = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk($sformatf("rekey%0d rk_idx", k), 128'(bus.rk_idx), 128'((k < 6) ? 5 - k : 12));
            chk($sformatf("rekey%0d key_rdy", k), 128'(bus.key_rdy), 128'(k == 6));
            cyc();
        end
        bus.key_vld = 1'b0;
        bus.rk_rdy  = 1'b0;
        @(negedge clk);
        chk("rekey+1 rk_vld", 128'(bus.rk_vld), 128'd0);
        chk("rekey+1 keys_ready", 128'(bus.keys_ready), 128'd0);
        chk("rekey+1 kx_kt_vld", 128'(bus.kx_kt_vld), 128'd1);
        repeat (13) cyc();
        @(negedge clk);
        chk("rekey+14 rk_vld", 128'(bus.rk_vld), 128'd1);
        chk("rekey+14 rk_idx", 128'(bus.rk_idx), 128'd12);
        chk("rekey rk12 const", bus.rk_out, 128'he98ba06f448c773c8ecc720401002202);
        chk("rekey rev0 const", bus0.rk_out, 128'h8e73b0f7da0e6452c810f32b809079e5);

        // Reset during CAPTURE
        cyc();
        bus.key_in  = KEY_C2;
        bus.key_vld = 1'b1;
        @(negedge clk);
        chk("rc accept key_rdy", 128'(bus.key_rdy), 128'd1);
        cyc();
        bus.key_vld = 1'b0;
        repeat (5) cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rc keys_ready", 128'(bus.keys_ready), 128'd0);
        chk("rc rk_vld", 128'(bus.rk_vld), 128'd0);
        chk("rc key_rdy", 128'(bus.key_rdy), 128'd1);
        chk("rc kx_kt_vld", 128'(bus.kx_kt_vld), 128'd0);

        // Reload A.2 with gaps in the expander stream
        exp_gap = 1'b1;
        cyc();
        bus.key_in  = KEY_A2;
        bus.key_vld = 1'b1;
        cyc();
        bus.key_vld = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.rk_vld && n < 80) begin
            chk("gap keys_ready early", 128'(bus.keys_ready), 128'd0);
            cyc();
            @(negedge clk);
            n++;
        end
        chk("gap reload rk_vld", 128'(bus.rk_vld), 128'd1);
        chk("gap reload keys_ready", 128'(bus.keys_ready), 128'd1);
        for (int k = 0; k < 13; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("gap idx%0d", k), 128'(bus.rk_idx), 128'(12 - k));
            chk($sformatf("gap out%0d", k), bus.rk_out, rk_of(gold_a2, 12 - k));
            bus.rk_rdy = 1'b1;
            cyc();
        end
        bus.rk_rdy = 1'b0;
        exp_gap    = 1'b0;

        // Early last at wr_ptr 7: sticky err, READY still entered
        exp_last_at = 7;
        bus.key_in  = KEY_C2;
        bus.key_vld = 1'b1;
        cyc();
        bus.key_vld = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.rk_vld && n < 40) begin
            cyc();
            @(negedge clk);
            n++;
        end
        chk("early rk_vld", 128'(bus.rk_vld), 128'd1);
        chk("early keys_ready", 128'(bus.keys_ready), 128'd1);
        chk("early err", 128'(bus.err), 128'd1);
        chk("early rev0 err", 128'(bus0.err), 128'd1);
        repeat (3) cyc();
        @(negedge clk);
        chk("early err sticky", 128'(bus.err), 128'd1);
        exp_last_at = 12;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk("err cleared by reset", 128'(bus.err), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_rkey_sched192.md
# aes_rkey_sched192

Round-key scheduler for the 192-bit AES decryption path. It accepts a cipher key, sequences the 192-bit key expander through one full expansion and captures the 13 round keys into an internal buffer. It then serves those keys to the decryption round datapath in inverse-cipher order (round 12 first), once per block, without re-running the expansion. It sits between the key-load interface of the core and the round datapath, and is the only agent that drives the expander.

## Interface
- REVERSE, default 1: 1 serves buffer index 12→0 (decrypt order); 0 serves 0→12.
- clk  in  1  rising-edge clock.
- rst_n  in  1  Synchronous, active-low reset.
- key_in  in  [0:191]  Cipher key.
- key_vld  in  1  Cipher key present.
- key_rdy  out  1  Scheduler will accept a key this cycle.
- kx_kt  out  [0:191]  Key to expander, held from the internal key register.
- kx_kt_vld  out  1  Key valid to expander.
- kx_kt_rdy  in  1  Expander ready; it sits at its initial state.
- kx_rkey  in  [0:127]  Round key from expander.
- kx_rkey_vld  in  1  Round key valid.
- kx_rkey_last  in  1  Last (13th) round key.
- rk_out  out  [0:127]  Round key for the datapath, equal to buf[rd_ptr].
- rk_vld  out  1  rk_out valid.
- rk_rdy  in  1  Datapath consumes rk_out this cycle.
- rk_idx  out  [3:0]  Buffer index currently presented.
- rk_last  out  1  Final key of the current block.
- keys_ready  out  1  Buffer holds a complete key set.
- err  out  1  Sticky error: kx_rkey_last arrived at an index other than 12.

## Operation
- Reset requirement: the top level drives the expander reset from ~rst_n, so both blocks reset together.
- The FSM has four states: IDLE, LOAD, CAPTURE, READY. Reset enters IDLE.
- Key accept:
  - key_rdy = IDLE, or READY with rd_ptr at its block-start index (not mid-block).
  - On key_vld & key_rdy: latch key_in into key_reg, clear keys_ready, go to LOAD.
- LOAD:
  - Assert kx_kt_vld with kx_kt = key_reg.
  - When kx_kt_rdy is high, the expander presents round key 0 combinationally that same cycle. If kx_rkey_vld is also high, write buf[0] and go to CAPTURE with wr_ptr = 1.
- CAPTURE:
  - kx_kt_vld = 0.
  - Each cycle with kx_rkey_vld: write buf[wr_ptr], then wr_ptr += 1.
  - On kx_rkey_last: write the entry. If wr_ptr ≠ 12, set err. Go to READY and set keys_ready.
  - A cycle with kx_rkey_vld low causes no write and no state change.
- READY:
  - rk_vld = 1.
  - rd_ptr starts at 12 if REVERSE = 1, else 0.
  - On rk_vld & rk_rdy: step rd_ptr toward the end index. rk_last is high at the end index (0 if REVERSE = 1, else 12).
  - When a transfer occurs with rk_last high, rd_ptr wraps to the start index for the next block. The buffer is retained.
- Rekey in READY (allowed only at block start): go to LOAD. rk_vld and keys_ready drop in the cycle after acceptance.
- Buffer: 13 × 128-bit registers. Writes occur only in LOAD and CAPTURE. Contents are undefined after reset and are never presented while rk_vld = 0.
- err clears only on reset.

## Timing
- Reset values: key_rdy = 1, kx_kt_vld = 0, rk_vld = 0, rk_last = 0, keys_ready = 0, err = 0, rk_idx = 0. kx_kt and rk_out are don't-care.
- Load latency (key accepted at cycle T, expander idle):
  - LOAD at T+1: kx_kt_vld high, buf[0] written.
  - buf[1..12] written at T+2..T+13.
  - READY, rk_vld and keys_ready high from T+14.
- Serving throughput: one key per cycle while rk_rdy is held high. A block of 13 keys takes 13 cycles, back-to-back with no bubble between blocks.
- rk_out, rk_idx and rk_last are combinational from rd_ptr and the state. They change only on the edge after a transfer.
- Reset mid-operation: rst_n low in any state returns to IDLE on the next edge. A partially captured buffer is never marked ready.
- key_vld asserted in LOAD, CAPTURE or mid-block READY: key_rdy = 0 and the key is not taken. The source must hold it.

## Test plan
- FIPS-197 C.2 key 000102…1617, REVERSE = 1, rk_rdy = 1 constant:
  - key_vld at T gives rk_vld at T+14.
  - rk_idx = 12 with rk_out = a4970a331a78dc09c418c271e3a41d5d.
  - rk_idx = 0 at T+26 with rk_out = 000102030405060708090a0b0c0d0e0f and rk_last = 1.
  - T+27 shows idx 12 again.
- Backpressure: toggle rk_rdy randomly. rk_out holds while rk_rdy = 0. The 13 keys are delivered in order with no skip or repeat. Three blocks give identical sequences.
- Rekey: second key FIPS-197 A.2 (8e73b0f7…6b7b) offered mid-block.
  - Refused until rk_last is consumed; accepted at block start.
  - New idx 12 key = e98ba06f448c773c8ecc720401002202.
- Reset during CAPTURE (rst_n = 0 at T+6):
  - Next edge gives IDLE, keys_ready = 0, rk_vld = 0.
  - A reload then completes normally.
- REVERSE = 0: first key served is 000102…0e0f, and rk_last is on idx 12.
- Injected early kx_rkey_last at wr_ptr = 7: err = 1 sticky, READY entered; err clears only on rst_n.
